chip_spreader: RTL and testbench



---
 rtl/chip_spreader_pkg.sv | 32 +++
 rtl/chip_spreader_if.sv | 25 ++
 rtl/chip_lut.sv | 19 +
 rtl/chip_spreader.sv | 107 ++++++++++
 tb/tb_chip_spreader.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chip_spreader_pkg.sv
// spreader_pkg: shared constants and types for the chip spreader.
//   BITS_PER_SYM / CHIPS_PER_SYM : symbol and chip-word widths
//   SYM0_CHIPS                   : PN sequence of symbol 0, bit i = chip c_i
//   ODD_CHIP_MASK                : selects c1, c3, ... (inverted for symbols 8-15)
//   state_t                      : framing FSM states
package spreader_pkg;

    localparam int BITS_PER_SYM  = 4;
    localparam int CHIPS_PER_SYM = 32;

    // Reverses a word so a sequence written c0-first in source lands with c0 at bit 0.
    function automatic logic [CHIPS_PER_SYM-1:0] rev_chips(input logic [CHIPS_PER_SYM-1:0] v);
        logic [CHIPS_PER_SYM-1:0] r;
        for (int i = 0; i < CHIPS_PER_SYM; i++) begin
            r[i] = v[CHIPS_PER_SYM-1-i];
        end
        return r;
    endfunction

    // Written c0..c31 left to right, then flipped so bit i = c_i.
    localparam logic [CHIPS_PER_SYM-1:0] SYM0_CHIPS =
        rev_chips(32'b11011001110000110101001000101110);

    localparam logic [CHIPS_PER_SYM-1:0] ODD_CHIP_MASK = 32'hAAAA_AAAA;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FLUSH   = 2'd2
    } state_t;

endpackage

// File: rtl/chip_spreader_if.sv
// chip_spreader_if: serial bit input and chip-word output of the spreader.
//   spreader_input / spreader_input_valid : LSB-first bit stream, valid high for a whole frame
//   chip_output       : 32-chip word, bit i = c_i
//   chip_output_valid : one-cycle pulse per new chip word
//   frame_done        : one-cycle pulse closing a frame
// master = bit source / word sink, slave = the spreader.
interface chip_spreader_if import spreader_pkg::*; ();

    logic                     spreader_input;
    logic                     spreader_input_valid;
    logic [CHIPS_PER_SYM-1:0] chip_output;
    logic                     chip_output_valid;
    logic                     frame_done;

    modport master (
        output spreader_input, spreader_input_valid,
        input  chip_output, chip_output_valid, frame_done
    );

    modport slave (
        input  spreader_input, spreader_input_valid,
        output chip_output, chip_output_valid, frame_done
    );

endinterface

// File: rtl/chip_lut.sv
// chip_lut: combinational symbol -> 32-chip PN word.
//   sym   in  4  data symbol {b3,b2,b1,b0}
//   chips out 32 chip word, bit i = c_i
// Symbols 1-7 are symbol 0 delayed by 4k chips; since bit i holds c_i, a delay is a
// rotate towards the MSB. Symbols 8-15 invert the odd-indexed chips of symbols 0-7.
module chip_lut import spreader_pkg::*; (
    input  logic [BITS_PER_SYM-1:0]  sym,
    output logic [CHIPS_PER_SYM-1:0] chips
);

    logic [2*CHIPS_PER_SYM-1:0] dbl;

    always_comb begin
        // Upper half of the shifted double word is the rotated sequence.
        dbl   = {SYM0_CHIPS, SYM0_CHIPS} << {sym[2:0], 2'b00};
        chips = dbl[2*CHIPS_PER_SYM-1:CHIPS_PER_SYM] ^ (sym[3] ? ODD_CHIP_MASK : '0);
    end

endmodule

// File: rtl/chip_spreader.sv
// chip_spreader: groups an LSB-first serial bit stream into 4-bit symbols and emits
// one 32-chip PN word per symbol, flushing a trailing partial symbol at frame end.
//   PAD_PARTIAL : 1 = zero-pad and emit a trailing 1-3 bit symbol, 0 = drop it
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : spreader_input/_valid in, chip_output/_valid and frame_done out
module chip_spreader import spreader_pkg::*; #(
    parameter bit PAD_PARTIAL = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    chip_spreader_if.slave  bus
);

    state_t                   state_q, state_d;
    logic [1:0]               bit_cnt_q, bit_cnt_d;
    logic [BITS_PER_SYM-1:0]  nib_q, nib_d;
    logic [CHIPS_PER_SYM-1:0] chip_q, chip_d;
    logic                     cvld_q, cvld_d;
    logic                     fdone_q, fdone_d;
    logic                     emit_q, emit_d;   // full symbol in nib_q, emit next edge
    logic                     pend_q, pend_d;   // padded word out, frame_done next edge
    logic [1:0]               idx;
    logic [CHIPS_PER_SYM-1:0] lut_chips;

    // nib_q holds the symbol being emitted both for a completed symbol (one edge after
    // b3, before the next b0 lands) and for a padded partial symbol in FLUSH.
    chip_lut u_lut (
        .sym   (nib_q),
        .chips (lut_chips)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        nib_d     = nib_q;
        chip_d    = chip_q;
        cvld_d    = 1'b0;
        fdone_d   = pend_q;
        emit_d    = 1'b0;
        pend_d    = 1'b0;
        idx       = bit_cnt_q;

        if (emit_q) begin
            chip_d = lut_chips;
            cvld_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.spreader_input_valid) state_d = COLLECT;
            end
            COLLECT: begin
                if (!bus.spreader_input_valid) state_d = FLUSH;
            end
            FLUSH: begin
                if (bit_cnt_q != 2'd0 && PAD_PARTIAL) begin
                    chip_d = lut_chips;   // high bits of nib_q are already zero
                    cvld_d = 1'b1;
                    pend_d = 1'b1;
                end else begin
                    fdone_d = 1'b1;
                end
                // A bit arriving here opens the next frame as its b0.
                idx       = 2'd0;
                bit_cnt_d = 2'd0;
                nib_d     = '0;
                state_d   = bus.spreader_input_valid ? COLLECT : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (bus.spreader_input_valid) begin
            // b0 clears the stale upper bits so a padded flush sees zeros there.
            if (idx == 2'd0) nib_d = {3'b000, bus.spreader_input};
            else             nib_d[idx] = bus.spreader_input;
            bit_cnt_d = idx + 2'd1;
            emit_d    = (idx == 2'd3);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= 2'd0;
            nib_q     <= '0;
            chip_q    <= '0;
            cvld_q    <= 1'b0;
            fdone_q   <= 1'b0;
            emit_q    <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            nib_q     <= nib_d;
            chip_q    <= chip_d;
            cvld_q    <= cvld_d;
            fdone_q   <= fdone_d;
            emit_q    <= emit_d;
            pend_q    <= pend_d;
        end
    end

    assign bus.chip_output       = chip_q;
    assign bus.chip_output_valid = cvld_q;
    assign bus.frame_done        = fdone_q;

endmodule

// File: tb/tb_chip_spreader.sv
// Bench for chip_spreader: a padded and an unpadded instance see identical stimulus.
// Expected words/frame_done pulses (with their cycle) are queued as frames are driven
// and compared against what the monitor records.
module tb_chip_spreader;

    typedef struct {
        bit          done;
        logic [31:0] data;
        int          cyc;
    } ev_t;

    localparam logic [31:0] LIT0 = 32'b11011001110000110101001000101110;
    localparam logic [31:0] LIT1 = 32'b11101101100111000011010100100010;
    localparam logic [31:0] LIT8 = 32'b10001100100101100000011101111011;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    ev_t         exp_q[2][$];
    ev_t         obs_q[2][$];
    logic [31:0] last_w[2] = '{32'h0, 32'h0};
    bit          ovl[2] = '{1'b0, 1'b0};

    chip_spreader_if bus0();
    chip_spreader_if bus1();

    chip_spreader #(.PAD_PARTIAL(1'b1)) dut_pad (
        .clk(clk), .reset_n(reset_n), .bus(bus0)
    );
    chip_spreader #(.PAD_PARTIAL(1'b0)) dut_nopad (
        .clk(clk), .reset_n(reset_n), .bus(bus1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [31:0] str2w(input logic [31:0] s);
        logic [31:0] w;
        for (int i = 0; i < 32; i++) w[i] = s[31-i];
        return w;
    endfunction

    // c_j of symbol s = c_{(j-4k) mod 32} of symbol 0, odd j inverted when s >= 8.
    function automatic logic [31:0] ref_chips(input logic [3:0] s);
        logic [31:0] str;
        logic [31:0] w;
        int k, src;
        str = LIT0;
        k = int'(s[2:0]);
        for (int j = 0; j < 32; j++) begin
            src  = (j - 4*k + 32) % 32;
            w[j] = str[31-src] ^ (s[3] && (j % 2 == 1));
        end
        return w;
    endfunction

    // ---------------- monitor ----------------
    task automatic mon(input int d, input logic v, input logic f, input logic [31:0] w);
        ev_t e;
        if (v && f) ovl[d] = 1'b1;
        if (v) begin
            e.done = 1'b0; e.data = w; e.cyc = cyc;
            obs_q[d].push_back(e);
            last_w[d] = w;
        end else if (f) begin
            e.done = 1'b1; e.data = 32'h0; e.cyc = cyc;
            obs_q[d].push_back(e);
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus0.chip_output_valid, bus0.frame_done, bus0.chip_output);
        mon(1, bus1.chip_output_valid, bus1.frame_done, bus1.chip_output);
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input logic v, input logic b);
        bus0.spreader_input_valid = v; bus0.spreader_input = b;
        bus1.spreader_input_valid = v; bus1.spreader_input = b;
    endtask

    task automatic push_exp(input int d, input bit done, input logic [31:0] data, input int c);
        ev_t e;
        e.done = done; e.data = data; e.cyc = c;
        exp_q[d].push_back(e);
    endtask

    // Bit j is driven on the negedge at cycle t0+j and taken on the next edge;
    // valid stays low for 'gap' cycles afterwards.
    task automatic send_frame(input logic [31:0] bits, input int n, input int gap);
        int t0, nf, r;
        logic [3:0] s;
        @(negedge clk);
        t0 = cyc;
        nf = n / 4;
        r  = n % 4;
        for (int k = 0; k < nf; k++) begin
            s = bits[4*k +: 4];
            push_exp(0, 1'b0, ref_chips(s), t0 + 4*k + 5);
            push_exp(1, 1'b0, ref_chips(s), t0 + 4*k + 5);
        end
        if (r != 0) begin
            s = bits[4*nf +: 4] & 4'((1 << r) - 1);
            push_exp(0, 1'b0, ref_chips(s), t0 + n + 2);
            push_exp(0, 1'b1, 32'h0, t0 + n + 3);
        end else begin
            push_exp(0, 1'b1, 32'h0, t0 + n + 2);
        end
        push_exp(1, 1'b1, 32'h0, t0 + n + 2);
        for (int j = 0; j < n; j++) begin
            if (j > 0) @(negedge clk);
            set_in(1'b1, bits[j]);
        end
        @(negedge clk);
        set_in(1'b0, 1'b0);
        repeat (gap - 1) @(negedge clk);
    endtask

    // Let the pipeline drain, then pop and compare everything queued so far.
    task automatic drain_scoreboard(input string name);
        ev_t e, o;
        logic [31:0] cur;
        repeat (12) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (exp_q[d].size() != obs_q[d].size()) begin
                failures++;
                $display("FAIL %s dut%0d event count: got %0d expected %0d",
                         name, d, obs_q[d].size(), exp_q[d].size());
            end
            while (exp_q[d].size() > 0 && obs_q[d].size() > 0) begin
                e = exp_q[d].pop_front();
                o = obs_q[d].pop_front();
                checks++;
                if (o.done !== e.done || o.data !== e.data || o.cyc != e.cyc) begin
                    failures++;
                    $display("FAIL %s dut%0d event: got done=%0b data=%h cyc=%0d expected done=%0b data=%h cyc=%0d",
                             name, d, o.done, o.data, o.cyc, e.done, e.data, e.cyc);
                end
            end
            exp_q[d].delete();
            obs_q[d].delete();
            checks++;
            if (ovl[d] !== 1'b0) begin
                failures++;
                $display("FAIL %s dut%0d valid/done overlap: got 1 expected 0", name, d);
            end
            cur = (d == 0) ? bus0.chip_output : bus1.chip_output;
            checks++;
            if (cur !== last_w[d]) begin
                failures++;
                $display("FAIL %s dut%0d chip_output hold: got %h expected %h", name, d, cur, last_w[d]);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        set_in(1'b0, 1'b0);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (bus0.chip_output !== 32'h0 || bus1.chip_output !== 32'h0) begin
            failures++;
            $display("FAIL reset chip_output: got %h/%h expected 0", bus0.chip_output, bus1.chip_output);
        end
        checks++;
        if (bus0.chip_output_valid !== 1'b0 || bus0.frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset outputs: got valid=%b done=%b expected 0/0",
                     bus0.chip_output_valid, bus0.frame_done);
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs_q[d].size() != 0) begin
                failures++;
                $display("FAIL reset pulses dut%0d: got %0d events expected 0", d, obs_q[d].size());
            end
        end
        drain_scoreboard("reset_idle");
    endtask

    task automatic test_sym0();
        send_frame(32'h0, 4, 3);
        drain_scoreboard("sym0");
        checks++;
        if (last_w[0] !== str2w(LIT0) || last_w[1] !== str2w(LIT0)) begin
            failures++;
            $display("FAIL sym0 word: got %h/%h expected %h", last_w[0], last_w[1], str2w(LIT0));
        end
    endtask

    task automatic test_byte_10();
        send_frame(32'h10, 8, 3);
        drain_scoreboard("byte_10");
        checks++;
        if (last_w[0] !== str2w(LIT1)) begin
            failures++;
            $display("FAIL byte_10 sym1 word: got %h expected %h", last_w[0], str2w(LIT1));
        end
    endtask

    task automatic test_sym8();
        send_frame(32'h8, 4, 3);
        drain_scoreboard("sym8");
        checks++;
        if (last_w[1] !== str2w(LIT8)) begin
            failures++;
            $display("FAIL sym8 word: got %h expected %h", last_w[1], str2w(LIT8));
        end
    endtask

    task automatic test_partial();
        // 1,0,1,1,1,1 LSB-first: symbol 13 then partial {0,0,1,1} = 3
        send_frame(32'h3D, 6, 3);
        drain_scoreboard("partial");
        checks++;
        if (last_w[0] !== ref_chips(4'd3)) begin
            failures++;
            $display("FAIL partial padded last word: got %h expected %h", last_w[0], ref_chips(4'd3));
        end
        checks++;
        if (last_w[1] !== ref_chips(4'd13)) begin
            failures++;
            $display("FAIL partial dropped last word: got %h expected %h", last_w[1], ref_chips(4'd13));
        end
    endtask

    task automatic test_back_to_back();
        // gap of 1: the next frame's b0 lands in the FLUSH cycle
        send_frame(32'h3D, 6, 1);
        send_frame(32'h5, 3, 1);
        send_frame(32'hA5, 8, 1);
        send_frame(32'hF, 4, 2);
        drain_scoreboard("back_to_back");
    endtask

    task automatic test_reset_mid();
        @(negedge clk); set_in(1'b1, 1'b1);
        @(negedge clk); set_in(1'b1, 1'b1);
        @(negedge clk); set_in(1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (bus0.chip_output !== 32'h0 || bus0.chip_output_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid async clear: got %h valid=%b expected 0", bus0.chip_output,
                     bus0.chip_output_valid);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        send_frame(32'h0, 4, 3);
        drain_scoreboard("reset_mid");
        checks++;
        if (last_w[0] !== str2w(LIT0)) begin
            failures++;
            $display("FAIL reset_mid word: got %h expected %h", last_w[0], str2w(LIT0));
        end
    endtask

    task automatic test_random();
        int n, gap;
        logic [31:0] bits;
        for (int f = 0; f < 8; f++) begin
            n    = $urandom_range(1, 11);
            gap  = $urandom_range(1, 3);
            bits = $urandom & ((32'h1 << n) - 1);
            send_frame(bits, n, gap);
        end
        drain_scoreboard("random");
    endtask

    initial begin
        set_in(1'b0, 1'b0);
        test_reset();
        test_sym0();
        test_byte_10();
        test_sym8();
        test_partial();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
